// File: rtl/intc_pkg.sv
// Register map and FSM encoding shared by the z80_int_controller files.
package intc_pkg;

  localparam logic [3:0] INTC_A_MASK  = 4'd8;
  localparam logic [3:0] INTC_A_VBASE = 4'd9;
  localparam logic [3:0] INTC_A_PEND  = 4'd10;
  localparam logic [3:0] INTC_A_EOI   = 4'd11;
  localparam logic [3:0] INTC_A_ISR   = 4'd12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StAck  = 2'd2
  } intc_state_e;

endpackage

// File: rtl/z80_int_controller_if.sv
// Z80 bus control strobes seen by the interrupt controller (data bus stays a plain inout).
interface z80_int_controller_if;
  logic       ncs;
  logic       nwr;
  logic       nrd;
  logic [3:0] addr;
  logic       nm1;
  logic       niorq;

  modport master (output ncs, nwr, nrd, addr, nm1, niorq);
  modport slave  (input  ncs, nwr, nrd, addr, nm1, niorq);
endinterface

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module intc_prio_enc #(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0] req_i,
  output logic [2:0]      idx_o,
  output logic            valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_int_controller.sv
// Vectored (mode-2) interrupt controller for the Kraft80 Z80 bus.
// Define INTC_INSERVICE_EN to add the in-service register and EOI-based nesting.
module z80_int_controller
  import intc_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic                 cpuclk,
  input  logic                 rst,
  z80_int_controller_if.slave  bus,
  inout  wire  [7:0]           data,
  input  logic [NSRC-1:0]      irq_in,
  output logic                 intr_out
);

  intc_state_e     state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d, pend_q, pend_d, irq_prev_q;
  logic [3:0]      vbase_q, vbase_d;
  logic [2:0]      cur_q, cur_d;
  logic            wr_seen_q;

  logic            inta, wr_act, wr_fire, rd_act, ack_take;
  logic [NSRC-1:0] gate, elig, elig_nxt, cur_oh, isr_rd;
  logic [2:0]      win_idx;
  logic            win_valid;
  logic [7:0]      dout;
  logic            oe;

  assign inta     = !bus.nm1 && !bus.niorq;
  assign wr_act   = !bus.ncs && !bus.nwr;
  assign wr_fire  = wr_act && !wr_seen_q;
  assign rd_act   = !bus.ncs && !bus.nrd;
  assign ack_take = (state_q == StReq) && inta;
  assign cur_oh   = NSRC'(1) << cur_q;

`ifdef INTC_INSERVICE_EN
  logic [NSRC-1:0] isr_q, isr_d;

  // A source is held off while it or any higher-priority source is in service.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    gate    = '0;
    for (int i = 0; i < NSRC; i++) begin
      blocked = blocked | isr_q[i];
      gate[i] = !blocked;
    end
  end

  always_comb begin
    logic done;
    done  = 1'b0;
    isr_d = isr_q;
    if (wr_fire && bus.addr == INTC_A_EOI) begin
      for (int i = 0; i < NSRC; i++) begin
        if (isr_q[i] && !done) begin
          isr_d[i] = 1'b0;
          done     = 1'b1;
        end
      end
    end
    if (ack_take) isr_d = isr_d | cur_oh;
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) isr_q <= '0;
    else     isr_q <= isr_d;
  end

  assign isr_rd = isr_q;
`else
  assign gate   = '1;
  assign isr_rd = '0;
`endif

  always_comb begin
    mask_d  = mask_q;
    vbase_d = vbase_q;
    pend_d  = pend_q;
    if (wr_fire && bus.addr == INTC_A_MASK)  mask_d  = data[NSRC-1:0];
    if (wr_fire && bus.addr == INTC_A_VBASE) vbase_d = data[7:4];
    if (wr_fire && bus.addr == INTC_A_PEND)  pend_d  = pend_d & ~data[NSRC-1:0];
    if (ack_take) pend_d = pend_d & ~cur_oh;
    // New edges are applied last so a set beats a simultaneous clear.
    pend_d = pend_d | (irq_in & ~irq_prev_q);
  end

  assign elig     = pend_q & mask_q & gate;
  assign elig_nxt = pend_d & mask_d & gate;

  intc_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req_i   (elig),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          cur_d   = win_idx;
          state_d = StReq;
        end
      end
      StReq: begin
        if (inta)                       state_d = StAck;
        else if (~|(elig_nxt & cur_oh)) state_d = StIdle;
      end
      StAck: begin
        if (!inta) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpuclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      vbase_q    <= '0;
      pend_q     <= '0;
      cur_q      <= '0;
      irq_prev_q <= '0;
      wr_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      vbase_q    <= vbase_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      irq_prev_q <= irq_in;
      wr_seen_q  <= wr_act;
    end
  end

  assign intr_out = (state_q == StReq);

  always_comb begin
    dout = '0;
    oe   = 1'b0;
    if (state_q == StAck && inta) begin
      dout = {vbase_q, cur_q, 1'b0};
      oe   = 1'b1;
    end else if (rd_act) begin
      case (bus.addr)
        INTC_A_MASK:  begin dout = 8'(mask_q);       oe = 1'b1; end
        INTC_A_VBASE: begin dout = {vbase_q, 4'h0};  oe = 1'b1; end
        INTC_A_PEND:  begin dout = 8'(pend_q);       oe = 1'b1; end
        INTC_A_ISR:   begin dout = 8'(isr_rd);       oe = 1'b1; end
        default:      begin dout = '0;               oe = 1'b0; end
      endcase
    end
  end

  assign data = (oe && !rst) ? dout : 'z;

endmodule

// File: doc/z80_int_controller.md
# z80_int_controller

Vectored interrupt controller for the Kraft80 Z80 bus that collects the `intr_out` lines of the peripheral modules (timer, UART, etc.). It prioritises pending requests and drives a single `intr_out` to the CPU. It responds to the Z80 interrupt-acknowledge cycle (M1 with IORQ both low) by placing a mode-2 vector on the data bus. It is the responder side of the request that peripherals such as the timer initiate, and it sits beside them on the shared chip-select/address decode.

## Interface
- `NSRC`, 4: number of request inputs, 1..8; index 0 is highest priority.
- `cpuclk` input 1: 4 MHz CPU clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data` inout 8: CPU data bus; driven only during register reads or the acknowledge cycle, otherwise high-Z.
- `ncs` input 1: peripheral chip select, active low.
- `nwr`, `nrd` input 1: CPU write/read strobes, active low.
- `addr` input 4: register select.
- `nm1`, `niorq` input 1: Z80 M1 and IORQ, active low; the acknowledge condition is `INTA = !nm1 & !niorq`.
- `irq_in` input NSRC: peripheral request levels, active high.
- `intr_out` output 1: request to the CPU, active high (board inverts to /INT).

## Operation
- Registers, selected by `ncs` low and `addr`:
  - 8 MASK (R/W): bit i set enables source i.
  - 9 VBASE (R/W): only bits [7:4] are stored; reads return bits [3:0] as 0.
  - 10 PEND (R, write-1-to-clear).
  - 11 EOI (W only; data ignored).
  - 12 ISR (R).
  - Other addresses are ignored, and reads of them leave `data` undriven.
- Write capture:
  - The write is acted on once per strobe, on the first `cpuclk` edge that sees `ncs|nwr` low.
  - It re-arms when the strobe goes high.
- Request capture: a rising edge on `irq_in[i]` (compared with its value registered on the previous edge) sets PEND[i]. Edge capture applies even when the source is masked.
- Eligibility: source i is eligible when PEND[i] and MASK[i] are both set and it passes the in-service gate (see Configuration). The winner is the lowest-index eligible source.
- State machine:
  - IDLE: if any source is eligible, latch its index into `cur` and go to REQ.
  - REQ:
    - `intr_out` is 1.
    - If INTA is seen, clear PEND[cur] (set ISR[cur] when configured) and go to ACK.
    - Else if `cur` is no longer eligible (masked or PEND cleared by the CPU), go to IDLE.
  - ACK:
    - `intr_out` is 0.
    - `data = {VBASE[7:4], cur[2:0], 1'b0}`, driven combinationally while INTA is low.
    - Go to IDLE on the first edge with INTA high.
- Register reads drive `data` combinationally while `ncs`, `nrd` and the address match. A read never coincides with INTA.
- `cur` is frozen for the whole of REQ and ACK.

## Timing
- Reset values:
  - `intr_out` = 0, `data` high-Z, state IDLE.
  - MASK, VBASE, PEND, ISR and `cur` all 0.
  - Previous-`irq_in` register = 0.
- Latency:
  - `irq_in` rising edge → PEND set at edge N.
  - IDLE→REQ at edge N+1; `intr_out` high after edge N+1.
- Simultaneous edge on `irq_in[i]` and W1C of PEND[i]: the set wins.
- A MASK write that disables `cur` during REQ drops `intr_out` on the next edge, unless INTA is sampled on that same edge, in which case the acknowledge proceeds.
- A new, higher-priority request during REQ does not replace `cur`. It is served on the next pass through IDLE.
- Reset asserted mid-acknowledge releases `data` immediately (asynchronously).

## Configuration
- Macro `INTC_INSERVICE_EN`.
- Defined:
  - The ISR register is implemented.
  - Source i passes the gate only if no ISR bit at index ≤ i is set.
  - An EOI write clears the lowest-index set ISR bit; an EOI with ISR = 0 is a no-op.
- Undefined:
  - No ISR register: reads of address 12 return 0 and EOI is ignored.
  - All sources pass the gate.
  - Back-to-back requests re-assert `intr_out` from IDLE one edge after ACK exits.

## Structure
- Package `intc_pkg` holds:
  - Address constants `INTC_A_MASK`, `INTC_A_VBASE`, `INTC_A_PEND`, `INTC_A_EOI`, `INTC_A_ISR`.
  - State encoding IDLE/REQ/ACK.
- Sub-module `intc_prio_enc`: NSRC-bit vector in, 3-bit index and `valid` out, lowest index wins; combinational.

## Test plan
- Reset, then a register read sweep → MASK = 0x00, VBASE = 0x00, PEND = 0x00, `intr_out` = 0, `data` high-Z.
- MASK = 0x0F, VBASE = 0xA0, pulse `irq_in[2]` → `intr_out` = 1 two edges later; INTA → `data` = 0xA4, PEND[2] cleared, `intr_out` = 0.
- Pulse `irq_in[3]` and `irq_in[1]` on the same edge → first acknowledge vector 0xA2, second 0xA6.
- MASK = 0x00, pulse `irq_in[0]` → PEND = 0x01 and `intr_out` stays 0; then write MASK = 0x01 → `intr_out` = 1.
- `INTC_INSERVICE_EN`: acknowledge source 2, then pulse `irq_in[3]` → no request; pulse `irq_in[0]` → vector 0xA0; two EOI writes → source 3 is then requested.
- In REQ for source 1, write PEND = 0x02 (W1C) → `intr_out` drops the next edge and the state returns to IDLE.
